// File: rtl/int_to_floating_point_pkg.sv
// rtl/int_to_floating_point_pkg.sv - shared FPU conversion widths, rounding modes and state encoding
package int_to_floating_point_pkg;

   localparam int INT_SIZE      = 64;
   localparam int MANTISSA_SIZE = 23;
   localparam int EXPONENT_SIZE = 8;
   localparam int PRECISION     = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
   localparam int EXP_BIAS      = 127;

   // Rounding-mode encoding shared with the float-to-int stage.
   localparam logic [1:0] RM_RZ  = 2'b00;
   localparam logic [1:0] RM_RUP = 2'b01;
   localparam logic [1:0] RM_RDN = 2'b10;
   localparam logic [1:0] RM_RNE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_ZERO  = 2'd3
   } conv_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - combinational rounding and packing of a normalised significand
module fp_round_pack
   import int_to_floating_point_pkg::*;
#(
   parameter int mantissa_size = MANTISSA_SIZE,
   parameter int exponent_size = EXPONENT_SIZE
) (
   input  logic                                 sign,
   input  logic [exponent_size-1:0]             exponent,
   input  logic [mantissa_size-1:0]             frac,
   input  logic                                 guard,
   input  logic                                 sticky,
   input  logic [1:0]                           mode,
   output logic [exponent_size+mantissa_size:0] packed_float,
   output logic                                 inexact
);

   logic                     inc;
   logic [mantissa_size:0]   frac_sum;
   logic [exponent_size-1:0] exp_out;

   always_comb begin
      inc = 1'b0;
      case (mode)
         RM_RZ:   inc = 1'b0;
         RM_RUP:  inc = !sign & (guard | sticky);
         RM_RDN:  inc = sign & (guard | sticky);
         default: inc = guard & (sticky | frac[0]);
      endcase
   end

   // A carry out of the fraction leaves it all-zero and bumps the exponent.
   assign frac_sum     = {1'b0, frac} + {{mantissa_size{1'b0}}, inc};
   assign exp_out      = exponent + {{(exponent_size-1){1'b0}}, frac_sum[mantissa_size]};
   assign packed_float = {sign, exp_out, frac_sum[mantissa_size-1:0]};
   assign inexact      = guard | sticky;

endmodule

// File: rtl/int_to_floating_point.sv
// rtl/int_to_floating_point.sv - iterative integer to IEEE-754 float converter with start/busy/done
module int_to_floating_point
   import int_to_floating_point_pkg::*;
#(
   parameter int int_size      = INT_SIZE,
   parameter int mantissa_size = MANTISSA_SIZE,
   parameter int exponent_size = EXPONENT_SIZE,
   parameter int precision     = PRECISION,
   parameter int exp_bias      = EXP_BIAS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [int_size-1:0]  int_in,
   input  logic                 is_signed,
   input  logic [1:0]           conv,
   output logic [precision-1:0] float,
   output logic                 busy,
   output logic                 done,
   output logic                 inexact_flag
);

   localparam int CNT_W = $clog2(int_size) + 1;

   conv_state_t              state;
   logic                     sign_q;
   logic [1:0]               mode_q;
   logic [int_size-1:0]      mag;
   logic [CNT_W-1:0]         count;

   logic                     sign_in;
   logic [int_size-1:0]      mag_in;
   logic [exponent_size-1:0] exp_pre;
   logic [precision-1:0]     rp_float;
   logic                     rp_inexact;

   // Negating INT_MIN wraps back to 2^(int_size-1), which is the correct magnitude.
   assign sign_in = is_signed & int_in[int_size-1];
   assign mag_in  = sign_in ? -int_in : int_in;
   assign exp_pre = exponent_size'(exp_bias + int_size - 1) - exponent_size'(count);

   fp_round_pack #(
      .mantissa_size (mantissa_size),
      .exponent_size (exponent_size)
   ) u_round_pack (
      .sign         (sign_q),
      .exponent     (exp_pre),
      .frac         (mag[int_size-2 -: mantissa_size]),
      .guard        (mag[int_size-2-mantissa_size]),
      .sticky       (|mag[int_size-3-mantissa_size:0]),
      .mode         (mode_q),
      .packed_float (rp_float),
      .inexact      (rp_inexact)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         float        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         inexact_flag <= 1'b0;
         sign_q       <= 1'b0;
         mode_q       <= RM_RZ;
         mag          <= '0;
         count        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sign_q <= sign_in;
                  mag    <= mag_in;
                  count  <= '0;
                  mode_q <= conv;
                  busy   <= 1'b1;
                  state  <= (mag_in == '0) ? ST_ZERO : ST_NORM;
               end
            end
            ST_NORM: begin
               if (mag[int_size-1]) begin
                  state <= ST_ROUND;
               end else begin
                  mag   <= mag << 1;
                  count <= count + CNT_W'(1);
               end
            end
            ST_ROUND: begin
               float        <= rp_float;
               inexact_flag <= rp_inexact;
               done         <= 1'b1;
               busy         <= 1'b0;
               state        <= ST_IDLE;
            end
            ST_ZERO: begin
               float        <= '0;
               inexact_flag <= 1'b0;
               done         <= 1'b1;
               busy         <= 1'b0;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_floating_point.sv
// tb/tb_int_to_floating_point.sv - randomized self-checking bench for int_to_floating_point
module tb_int_to_floating_point;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [63:0] int_in = '0;
   logic        is_signed = 1'b0;
   logic [1:0]  conv = 2'b00;
   logic [31:0] flt;
   logic        busy, done, inexact_flag;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] f;
      logic        ix;
      int          lat;
      int          acc;
   } exp_t;
   exp_t q[$];

   int_to_floating_point dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .int_in       (int_in),
      .is_signed    (is_signed),
      .conv         (conv),
      .float        (flt),
      .busy         (busy),
      .done         (done),
      .inexact_flag (inexact_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference: locate the leading one, then round the discarded tail by value comparison.
   function automatic logic [32:0] model(input logic [63:0] v, input logic sg, input logic [1:0] m);
      logic        s, ix, inc;
      logic [63:0] mag, sig, rem, half;
      int          p, e, sh;
      s   = sg & v[63];
      mag = s ? (~v + 64'd1) : v;
      p   = -1;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      if (p < 0) return '0;
      e   = 127 + p;
      ix  = 1'b0;
      inc = 1'b0;
      if (p <= 23) begin
         sig = mag << (23 - p);
      end else begin
         sh   = p - 23;
         sig  = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         ix   = (rem != 0);
         case (m)
            2'd0:    inc = 1'b0;
            2'd1:    inc = !s && ix;
            2'd2:    inc = s && ix;
            default: inc = (rem > half) || (rem == half && sig[0]);
         endcase
      end
      sig = sig + {63'd0, inc};
      if (sig == 64'h100_0000) begin
         sig = sig >> 1;
         e++;
      end
      return {ix, s, e[7:0], sig[22:0]};
   endfunction

   function automatic int latency(input logic [63:0] v, input logic sg);
      logic [63:0] mag;
      int p;
      mag = (sg & v[63]) ? (~v + 64'd1) : v;
      p = -1;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      return (p < 0) ? 1 : (63 - p) + 2;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         check("busy", {63'd0, busy}, {63'd0, (q.size() != 0) && !done});
         if (done) begin
            if (q.size() == 0) begin
               check("done_without_request", {63'd0, done}, 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("float", {32'd0, flt}, {32'd0, e.f});
               check("inexact", {63'd0, inexact_flag}, {63'd0, e.ix});
               check("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
         end
      end
   end

   // Called at a negedge while the DUT is idle; returns just after the accepting edge.
   task automatic issue(input logic [63:0] v, input logic sg, input logic [1:0] m);
      exp_t        e;
      logic [32:0] r;
      start     = 1'b1;
      int_in    = v;
      is_signed = sg;
      conv      = m;
      @(posedge clk);
      #1;
      r     = model(v, sg, m);
      e.f   = r[31:0];
      e.ix  = r[32];
      e.lat = latency(v, sg);
      e.acc = cyc;
      q.push_back(e);
      start     = 1'b0;
      int_in    = {$urandom, $urandom};
      is_signed = 1'($urandom);
      conv      = 2'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         check("done_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   task automatic convert(input logic [63:0] v, input logic sg, input logic [1:0] m);
      wait_idle();
      @(negedge clk);
      issue(v, sg, m);
   endtask

   task automatic convert_b2b(input logic [63:0] v, input logic sg, input logic [1:0] m);
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      issue(v, sg, m);
   endtask

   task automatic directed(input string name, input logic [63:0] v, input logic sg,
                           input logic [1:0] m, input logic [31:0] lit_f, input logic lit_ix);
      check(name, {31'd0, model(v, sg, m)}, {31'd0, lit_ix, lit_f});
      convert(v, sg, m);
   endtask

   initial begin
      logic [63:0] v;
      #2;
      check("reset_float", {32'd0, flt}, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_inexact", {63'd0, inexact_flag}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      directed("one_rne",     64'd1,                  1'b0, 2'b11, 32'h3F80_0000, 1'b0);
      directed("minus_one",   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b00, 32'hBF80_0000, 1'b0);
      directed("int_min",     64'h8000_0000_0000_0000, 1'b1, 2'b00, 32'hDF00_0000, 1'b0);
      directed("zero_signed", 64'd0,                  1'b1, 2'b10, 32'h0000_0000, 1'b0);
      directed("tie_rne",     64'd16777217,           1'b0, 2'b11, 32'h4B80_0000, 1'b1);
      directed("tie_rz",      64'd16777217,           1'b0, 2'b00, 32'h4B80_0000, 1'b1);
      directed("tie_rup",     64'd16777217,           1'b0, 2'b01, 32'h4B80_0001, 1'b1);
      directed("tie_rdn",     64'd16777217,           1'b0, 2'b10, 32'h4B80_0000, 1'b1);
      directed("max_rne",     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b11, 32'h5F80_0000, 1'b1);
      directed("max_rz",      64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b00, 32'h5F7F_FFFF, 1'b1);

      // Start pulsed while busy must not disturb the running conversion.
      convert(64'd1, 1'b0, 2'b11);
      repeat (5) @(negedge clk);
      start = 1'b1; int_in = 64'h0000_0123_4567_89AB; is_signed = 1'b0; conv = 2'b01;
      @(negedge clk);
      start = 1'b0;

      // Start held in the done cycle is accepted.
      convert_b2b(64'h0000_0000_00FF_FFFF, 1'b0, 2'b11);
      convert_b2b(64'd0, 1'b0, 2'b00);
      convert_b2b(64'hFFFF_FFFF_FFFF_FF00, 1'b1, 2'b01);

      // Reset mid-normalisation drops the conversion with no done.
      convert(64'd1, 1'b0, 2'b11);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_busy", {63'd0, busy}, 64'd0);
      check("midreset_done", {63'd0, done}, 64'd0);
      check("midreset_float", {32'd0, flt}, 64'd0);
      check("midreset_inexact", {63'd0, inexact_flag}, 64'd0);
      q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (70) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         v = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 9) == 0) v = '0;
         if ($urandom_range(0, 3) == 0)
            convert_b2b(v, 1'($urandom), 2'($urandom));
         else
            convert(v, 1'($urandom), 2'($urandom));
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/int_to_floating_point.md
Name: int_to_floating_point

Overview:
- Multi-cycle converter from a signed or unsigned integer to an IEEE-754 binary float.
- Sits directly upstream of the float-to-int stage in the FPU conversion path.
- Uses the same rounding-mode encoding on conv, so the pair round-trips under a shared control word.
- Normalisation is iterative, one bit per cycle; results are returned through a start/busy/done handshake.

Parameters:
- int_size, 64, integer operand width.
- mantissa_size, 23, stored fraction bits.
- exponent_size, 8, exponent field bits.
- precision, 32, total float width (1 + exponent_size + mantissa_size).
- exp_bias, 127, exponent bias.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- int_in  in  int_size  integer operand; captured on the accepting edge.
- is_signed  in  1  1 = int_in is two's complement; 0 = unsigned.
- conv  in  2  rounding mode, captured with the operand: 00 toward zero, 01 toward +inf, 10 toward -inf, 11 nearest-even.
- float  out  precision  result; held until the next done.
- busy  out  1  high while a conversion is in flight.
- done  out  1  one-cycle pulse when float is valid.
- inexact_flag  out  1  1 = the result was rounded; valid with done and held afterwards.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE; float=0, busy=0, done=0, inexact_flag=0; internal magnitude and counters cleared. An in-flight conversion is dropped and no done is issued.
- IDLE, start=1 at an edge:
  - capture sign = is_signed & int_in[int_size-1];
  - mag = sign ? (~int_in+1) : int_in, as an unsigned int_size value (INT_MIN yields 2^(int_size-1) exactly);
  - shift count = 0; latch conv; busy=1.
  - Next state: ZERO if mag==0, otherwise NORM.
- IDLE, start=0: hold all outputs; done=0.
- NORM:
  - if mag[int_size-1]==1, go to ROUND;
  - else mag <= mag<<1 and count+1.
  - Count width is clog2(int_size)+1.
- ROUND:
  - exponent = exp_bias + int_size-1-count;
  - frac = mag[int_size-2 -: mantissa_size];
  - guard = next lower bit; sticky = OR of all remaining lower bits; lsb = frac[0];
  - inc decided by mode: 00 never; 01 if !sign & (g|s); 10 if sign & (g|s); 11 if g & (s|lsb).
  - If frac+inc carries out: frac = 0, exponent+1. No overflow to infinity is reachable at the default sizes (max exponent 191).
  - Write float = {sign, exponent, frac}; inexact_flag = g|s; done=1; busy=0; next state IDLE.
- ZERO: float=0 (+0, also for signed input), inexact_flag=0, done=1, busy=0, next state IDLE.
- Latency, counting edges after the accepting edge until done is high:
  - nonzero operand: lz+2, where lz = leading zeros of mag;
  - zero operand: 1.
  - Worst case 65 (value 1).
- done is high for exactly one cycle, in the same cycle busy falls.
- start while busy is ignored; it is not queued.
- start asserted in the cycle done is high is accepted, because the state is IDLE at that edge.
- int_in, is_signed and conv may change freely after acceptance without affecting the result.
- Subnormal outputs cannot occur and need no handling.

Decomposition:
- Shared fpu package:
  - rounding-mode constants RM_RZ=2'b00, RM_RUP=2'b01, RM_RDN=2'b10, RM_RNE=2'b11, also used by the float-to-int stage;
  - single-precision field widths and exp_bias.
- Natural sub-module: fp_round_pack. It is combinational and takes sign, exponent, frac, guard, sticky and mode; it returns the packed float and inexact. Reuse it later in the add/mul stages.
- The FSM and normaliser stay in the top module.

Test Plan:
- Unsigned 1, mode 11 → float=0x3F800000, inexact=0, done exactly 65 cycles after the accepting edge, busy high throughout.
- Signed -1 (all ones), then signed INT_MIN (0x8000000000000000), mode 00 → 0xBF800000 then 0xDF000000, inexact=0 for both.
- Zero, signed, any mode → float=0x00000000, done 1 cycle after start, inexact=0.
- Unsigned 16777217 (2^24+1), modes 11 / 00 / 01 / 10 → 0x4B800000 / 0x4B800000 / 0x4B800001 / 0x4B800000, inexact=1 in all modes.
- Unsigned 0xFFFFFFFFFFFFFFFF: mode 11 → 0x5F800000 (carry bumps exponent); mode 00 → 0x5F7FFFFF; inexact=1 in both.
- Handshake and reset cases:
  - start pulsed while busy → ignored, first result unaffected;
  - reset asserted mid-NORM → busy, done, float and inexact go to 0 immediately, no done pulse;
  - back-to-back start in the done cycle → accepted.
